// File: rtl/rca_accumulator_pkg.sv
// Common types and encodings for the ripple-carry accumulator.
package rca_accumulator_pkg;
`include "rca_defs.vh"

   typedef struct packed {
      logic [3:0] sum;
      logic       carry;
      logic       overflow;
   } addsub_res_t;
endpackage

// File: rtl/acc_addsub.sv
// 4-bit ripple-carry add/subtract: a + (b ^ {4{dir}}) + dir.
module acc_addsub (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       dir,
   output logic [3:0] sum,
   output logic       c3,
   output logic       ovf
);
   logic [3:0] b_x;
   logic [4:0] c;

   assign b_x  = b ^ {4{dir}};
   assign c[0] = dir;

   // c[i+1] is the carry out of bit i
   for (genvar i = 0; i < 4; i++) begin : g_fa
      full_adder u_fa (
         .a    (a[i]),
         .b    (b_x[i]),
         .cin  (c[i]),
         .s    (sum[i]),
         .cout (c[i+1])
      );
   end

   assign c3  = c[4];
   assign ovf = c[3] ^ c[4];
endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell for the ripple-carry chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/rca_defs.vh
// Shared encodings for the rca_accumulator sequencer: FSM state codes and dir codes.
`ifndef RCA_DEFS_VH
`define RCA_DEFS_VH
localparam logic [1:0] IDLE = 2'd0;
localparam logic [1:0] EXEC = 2'd1;
localparam logic [1:0] HOLD = 2'd2;
localparam logic       ADD  = 1'b0;
localparam logic       SUB  = 1'b1;
`endif

// File: rtl/rca_accumulator.sv
// Handshaked 4-bit accumulator: accept operand, execute one cycle, hold result.
//   state | meaning
//   IDLE  | waiting for an operand (in_ready=1)
//   EXEC  | one-cycle add/subtract into acc
//   HOLD  | result presented until out_ready (out_valid=1)
module rca_accumulator
   import rca_accumulator_pkg::*;
#(
   parameter int STICKY_OVF = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] operand,
   input  logic       dir,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] acc,
   output logic       carry,
   output logic       overflow,
   output logic       ovf_sticky
);
   logic [1:0]  state;
   logic [3:0]  op_q;
   logic        dir_q;
   addsub_res_t res;

   acc_addsub u_addsub (
      .a   (acc),
      .b   (op_q),
      .dir (dir_q),
      .sum (res.sum),
      .c3  (res.carry),
      .ovf (res.overflow)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == HOLD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         op_q       <= 4'd0;
         dir_q      <= 1'b0;
         acc        <= 4'd0;
         carry      <= 1'b0;
         overflow   <= 1'b0;
         ovf_sticky <= 1'b0;
      end else if (clear) begin
         state      <= IDLE;
         acc        <= 4'd0;
         carry      <= 1'b0;
         overflow   <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q  <= operand;
                  dir_q <= dir;
                  state <= EXEC;
               end
            end
            EXEC: begin
               acc        <= res.sum;
               carry      <= res.carry;
               overflow   <= res.overflow;
               ovf_sticky <= (STICKY_OVF != 0) ? (ovf_sticky | res.overflow) : 1'b0;
               state      <= HOLD;
            end
            HOLD: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rca_accumulator.sv
// Self-checking bench for rca_accumulator: directed cases plus randomized traffic vs. a model.
module tb_rca_accumulator;
   import rca_accumulator_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] operand = 4'd0;
   logic       dir = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] acc;
   logic       carry;
   logic       overflow;
   logic       ovf_sticky;

   int checks = 0;
   int errors = 0;

   rca_accumulator #(.STICKY_OVF(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .operand    (operand),
      .dir        (dir),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .acc        (acc),
      .carry      (carry),
      .overflow   (overflow),
      .ovf_sticky (ovf_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: acceptance, one execute cycle, then a held result.
   logic [3:0] m_acc = 4'd0;
   logic       m_carry = 1'b0, m_ovf = 1'b0, m_sticky = 1'b0;
   bit         m_accepting = 1'b1, m_pending = 1'b0, m_presenting = 1'b0;
   logic [3:0] q_op;
   logic       q_dir;

   always @(posedge clk or posedge rst) begin
      int sa, sb, r;
      if (rst) begin
         m_acc = 0; m_carry = 0; m_ovf = 0; m_sticky = 0;
         m_accepting = 1; m_pending = 0; m_presenting = 0;
      end else if (clear) begin
         m_acc = 0; m_carry = 0; m_ovf = 0; m_sticky = 0;
         m_accepting = 1; m_pending = 0; m_presenting = 0;
      end else if (m_accepting && in_valid) begin
         q_op = operand; q_dir = dir;
         m_accepting = 0; m_pending = 1;
      end else if (m_pending) begin
         sa = (m_acc >= 8) ? int'(m_acc) - 16 : int'(m_acc);
         sb = (q_op >= 8) ? int'(q_op) - 16 : int'(q_op);
         r  = (q_dir == SUB) ? sa - sb : sa + sb;
         m_ovf   = (r > 7) || (r < -8);
         m_carry = (q_dir == SUB) ? (m_acc >= q_op) : (int'(m_acc) + int'(q_op) > 15);
         m_acc   = 4'(r);
         m_sticky = m_sticky | m_ovf;
         m_pending = 0; m_presenting = 1;
      end else if (m_presenting && out_ready) begin
         m_presenting = 0; m_accepting = 1;
      end
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, m_accepting);
      chk("out_valid", out_valid, m_presenting);
      chk("acc", acc, m_acc);
      chk("carry", carry, m_carry);
      chk("overflow", overflow, m_ovf);
      chk("ovf_sticky", ovf_sticky, m_sticky);
   end

   // Issue one operation with out_ready=1; returns at the negedge after the result cycle.
   task automatic do_op(input logic [3:0] op, input logic d,
                        input int e_acc, input int e_c, input int e_o, input int e_s,
                        input string tag);
      in_valid = 1; operand = op; dir = d; out_ready = 1;
      @(negedge clk);
      in_valid = 0; operand = 4'($urandom); dir = 1'($urandom);
      @(negedge clk);
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_acc"}, acc, e_acc);
      if (e_c >= 0) chk({tag, "_carry"}, carry, e_c);
      chk({tag, "_ovf"}, overflow, e_o);
      chk({tag, "_sticky"}, ovf_sticky, e_s);
      @(negedge clk);
      chk({tag, "_valid_1cyc"}, out_valid, 0);
   endtask

   initial begin
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_acc", acc, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      @(negedge clk);

      do_op(4'd3, ADD, 3, 0, 0, 0, "add3");
      do_op(4'd4, ADD, 7, 0, 0, 0, "add4");
      do_op(4'd2, ADD, 9, 0, 1, 1, "add2_ovf");
      do_op(4'd1, SUB, 8, -1, 0, 1, "sub1_sticky");

      clear = 1; @(negedge clk); clear = 0;
      do_op(4'd1, SUB, 15, 0, 0, 0, "sub_from0");
      do_op(4'd9, ADD, 8, -1, 0, 0, "to8");
      do_op(4'd1, SUB, 7, 1, 1, 1, "sub_from8");

      // Back-pressure: hold HOLD with a competing operand on the input.
      in_valid = 1; operand = 4'd2; dir = ADD; out_ready = 0;
      @(negedge clk);
      operand = 4'd5;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_acc", acc, 9);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         @(negedge clk);
      end
      in_valid = 0; out_ready = 1;
      @(negedge clk);
      chk("bp_release_idle", in_ready, 1);
      chk("bp_acc_after", acc, 9);

      // Clear while executing.
      in_valid = 1; operand = 4'd3; dir = ADD;
      @(negedge clk);
      in_valid = 0; clear = 1;
      @(negedge clk);
      clear = 0;
      chk("clr_exec_valid", out_valid, 0);
      chk("clr_exec_acc", acc, 0);
      chk("clr_exec_sticky", ovf_sticky, 0);
      chk("clr_exec_idle", in_ready, 1);
      @(negedge clk);
      chk("clr_exec_no_result", out_valid, 0);

      // Clear in IDLE beats a simultaneous in_valid.
      do_op(4'd6, ADD, 6, 0, 0, 0, "pre_clr");
      clear = 1; in_valid = 1; operand = 4'd4;
      @(negedge clk);
      clear = 0; in_valid = 0;
      chk("clr_idle_acc", acc, 0);
      chk("clr_idle_ready", in_ready, 1);
      @(negedge clk);
      chk("clr_idle_not_taken", in_ready, 1);
      chk("clr_idle_no_valid", out_valid, 0);

      // Asynchronous reset in the middle of HOLD.
      in_valid = 1; operand = 4'd5; dir = ADD; out_ready = 0;
      @(negedge clk);
      in_valid = 0;
      @(negedge clk);
      chk("pre_rst_valid", out_valid, 1);
      #2 rst = 1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_acc", acc, 0);
      chk("arst_in_ready", in_ready, 1);
      @(negedge clk);
      chk("arst_held_ready", in_ready, 1);
      rst = 0;

      // Randomized traffic, checked every cycle by the model comparator.
      for (int i = 0; i < 3000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         operand   = 4'($urandom);
         dir       = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         clear     = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 300) == 0) begin
            #3 rst = 1;
            #2 rst = 0;
         end
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
